// File: rtl/icache_fill_ctrl_pkg.sv
// Shared types and constants for the I-cache miss/fill controller.
// Contents: bus command encoding, MSHR entry layout, cache geometry
// (index/tag/line-offset widths) and the line-to-byte-address helper.
package icache_fill_ctrl_pkg;

  localparam int ADDR_W       = 32;
  localparam int ICACHE_IDX_W = 7;
  localparam int LINE_OFF_W   = 3;
  localparam int ICACHE_TAG_W = ADDR_W - ICACHE_IDX_W - LINE_OFF_W;
  localparam int LINE_ADDR_W  = ICACHE_TAG_W + ICACHE_IDX_W;
  localparam int LINE_W       = 64;
  localparam int NUM_MSHR     = 4;
  localparam int MSHR_IDX_W   = 2;
  localparam int PF_DEPTH     = 2;
  localparam int MEM_TAG_W    = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_e;

  typedef struct packed {
    logic                   vld;
    logic                   sent;
    logic                   is_pf;
    logic [LINE_ADDR_W-1:0] line;
    logic [MEM_TAG_W-1:0]   mem_tag;
  } mshr_entry_t;

  function automatic logic [ADDR_W-1:0] line_to_addr(input logic [LINE_ADDR_W-1:0] line);
    return {line, {LINE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_fill_ctrl_mshr.sv
// MSHR table for the I-cache fill controller.
// Holds NUM_MSHR outstanding line requests and provides:
//   dmd_line_i/dmd_match_o  line CAM for the demand lookup
//   pf_line_i/pf_match_o    line CAM for the prefetch probe
//   free_avail_o, alloc_*   one allocation per cycle via a circular pointer
//   iss_vld_o/iss_line_o    oldest valid-but-unsent entry; iss_resp_i != 0
//                           marks it sent and records the memory tag
//   ret_tag_i/ret_hit_o     memory tag match against sent entries; a hit
//                           frees the entry at the same edge
module icache_mshr
  import icache_fill_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_ADDR_W-1:0] dmd_line_i,
  output logic                   dmd_match_o,
  input  logic [LINE_ADDR_W-1:0] pf_line_i,
  output logic                   pf_match_o,
  output logic                   free_avail_o,
  input  logic                   alloc_en_i,
  input  logic [LINE_ADDR_W-1:0] alloc_line_i,
  input  logic                   alloc_is_pf_i,
  output logic                   iss_vld_o,
  output logic [LINE_ADDR_W-1:0] iss_line_o,
  input  logic [MEM_TAG_W-1:0]   iss_resp_i,
  input  logic [MEM_TAG_W-1:0]   ret_tag_i,
  output logic                   ret_hit_o,
  output logic [LINE_ADDR_W-1:0] ret_line_o
);

  mshr_entry_t             ent_q [NUM_MSHR];
  mshr_entry_t             ent_d [NUM_MSHR];
  // older_q[i][j] = entry i was allocated before entry j
  logic [NUM_MSHR-1:0]     older_q [NUM_MSHR];
  logic [NUM_MSHR-1:0]     older_d [NUM_MSHR];
  logic [MSHR_IDX_W-1:0]   alloc_ptr_q, alloc_ptr_d;

  logic [MSHR_IDX_W-1:0]   alloc_slot;
  logic [MSHR_IDX_W-1:0]   iss_sel;
  logic [MSHR_IDX_W-1:0]   ret_sel;
  logic [NUM_MSHR-1:0]     cand;
  logic                    blk;
  logic [MSHR_IDX_W-1:0]   slot;

  always_comb begin
    dmd_match_o  = 1'b0;
    pf_match_o   = 1'b0;
    free_avail_o = 1'b0;
    alloc_slot   = '0;
    iss_vld_o    = 1'b0;
    iss_sel      = '0;
    ret_hit_o    = 1'b0;
    ret_sel      = '0;
    cand         = '0;
    blk          = 1'b0;
    slot         = '0;

    for (int i = 0; i < NUM_MSHR; i++) begin
      if (ent_q[i].vld && ent_q[i].line == dmd_line_i) dmd_match_o = 1'b1;
      if (ent_q[i].vld && ent_q[i].line == pf_line_i)  pf_match_o  = 1'b1;
      cand[i] = ent_q[i].vld & ~ent_q[i].sent;
    end

    // First free slot at or after the alloc pointer; scanned backwards so
    // the nearest one wins.
    for (int k = NUM_MSHR - 1; k >= 0; k--) begin
      slot = alloc_ptr_q + MSHR_IDX_W'(k);
      if (!ent_q[slot].vld) begin
        free_avail_o = 1'b1;
        alloc_slot   = slot;
      end
    end

    // Oldest unsent: the candidate no other candidate is older than.
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (cand[i]) begin
        blk = 1'b0;
        for (int j = 0; j < NUM_MSHR; j++) begin
          if (cand[j] && older_q[j][i]) blk = 1'b1;
        end
        if (!blk) begin
          iss_vld_o = 1'b1;
          iss_sel   = MSHR_IDX_W'(i);
        end
      end
    end

    // Tag 0 means "no data"; stale tags of freed entries never match.
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (ret_tag_i != '0 && ent_q[i].vld && ent_q[i].sent &&
          ent_q[i].mem_tag == ret_tag_i) begin
        ret_hit_o = 1'b1;
        ret_sel   = MSHR_IDX_W'(i);
      end
    end
  end

  assign iss_line_o = ent_q[iss_sel].line;
  assign ret_line_o = ent_q[ret_sel].line;

  always_comb begin
    ent_d       = ent_q;
    older_d     = older_q;
    alloc_ptr_d = alloc_ptr_q;

    if (iss_vld_o && iss_resp_i != '0) begin
      ent_d[iss_sel].sent    = 1'b1;
      ent_d[iss_sel].mem_tag = iss_resp_i;
    end

    if (ret_hit_o) ent_d[ret_sel].vld = 1'b0;

    // Free vector is the pre-edge one, so a slot freed this cycle is only
    // reusable next cycle.
    if (alloc_en_i && free_avail_o) begin
      ent_d[alloc_slot].vld     = 1'b1;
      ent_d[alloc_slot].sent    = 1'b0;
      ent_d[alloc_slot].is_pf   = alloc_is_pf_i;
      ent_d[alloc_slot].line    = alloc_line_i;
      ent_d[alloc_slot].mem_tag = '0;
      alloc_ptr_d               = alloc_slot + 1'b1;
      for (int j = 0; j < NUM_MSHR; j++) begin
        older_d[j][alloc_slot] = ent_q[j].vld;
      end
      older_d[alloc_slot] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_MSHR; i++) ent_q[i].vld <= 1'b0;
      alloc_ptr_q <= '0;
    end else begin
      ent_q       <= ent_d;
      older_q     <= older_d;
      alloc_ptr_q <= alloc_ptr_d;
    end
  end

endmodule

// File: rtl/icache_fill_ctrl.sv
// I-cache miss/fill controller.
// Detects demand misses, tracks them in the MSHR table, issues line loads
// on the tagged memory bus, writes returned lines into the cache and runs a
// sequential next-line prefetcher that probes the cache ahead of the last
// demand miss.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req_i, if_pc_i             fetch request and byte address
//   rd_idx_o, rd_tag_o, rd_hit_i  demand lookup into the cache array
//   pf_idx_o, pf_tag_o, pf_hit_i  prefetch probe into the cache array
//   wr_en_o, wr_idx_o, wr_tag_o,
//   wr_data_o                     registered line fill
//   proc2mem_command_o/addr_o     load request (combinational)
//   mem2proc_response_i           accept tag for the request (0 = stall)
//   mem2proc_data_i/tag_i         returned line and its transaction tag
module icache_fill_ctrl
  import icache_fill_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_i,
  input  logic [ADDR_W-1:0]       if_pc_i,
  output logic [ICACHE_IDX_W-1:0] rd_idx_o,
  output logic [ICACHE_TAG_W-1:0] rd_tag_o,
  input  logic                    rd_hit_i,
  output logic [ICACHE_IDX_W-1:0] pf_idx_o,
  output logic [ICACHE_TAG_W-1:0] pf_tag_o,
  input  logic                    pf_hit_i,
  output logic                    wr_en_o,
  output logic [ICACHE_IDX_W-1:0] wr_idx_o,
  output logic [ICACHE_TAG_W-1:0] wr_tag_o,
  output logic [LINE_W-1:0]       wr_data_o,
  output logic [1:0]              proc2mem_command_o,
  output logic [ADDR_W-1:0]       proc2mem_addr_o,
  input  logic [MEM_TAG_W-1:0]    mem2proc_response_i,
  input  logic [LINE_W-1:0]       mem2proc_data_i,
  input  logic [MEM_TAG_W-1:0]    mem2proc_tag_i
);

  logic [LINE_ADDR_W-1:0] dmd_line;
  logic                   dmd_match, pf_match, free_avail;
  logic                   dmd_alloc, pf_alloc, pf_probe_miss, pf_adv;
  logic                   alloc_en, alloc_is_pf;
  logic [LINE_ADDR_W-1:0] alloc_line;
  logic                   iss_vld, ret_hit;
  logic [LINE_ADDR_W-1:0] iss_line, ret_line;

  logic                   pf_active_q, pf_active_d;
  logic [LINE_ADDR_W-1:0] pf_line_q, pf_line_d;
  logic [LINE_ADDR_W-1:0] pf_limit_q, pf_limit_d;
  logic                   wr_en_q, wr_en_d;
  logic [LINE_ADDR_W-1:0] wr_line_q, wr_line_d;
  logic [LINE_W-1:0]      wr_data_q, wr_data_d;

  assign dmd_line = if_pc_i[ADDR_W-1:LINE_OFF_W];
  assign rd_idx_o = if_pc_i[ICACHE_IDX_W+LINE_OFF_W-1:LINE_OFF_W];
  assign rd_tag_o = if_pc_i[ADDR_W-1:ICACHE_IDX_W+LINE_OFF_W];

  assign pf_idx_o = pf_active_q ? pf_line_q[ICACHE_IDX_W-1:0] : '0;
  assign pf_tag_o = pf_active_q ? pf_line_q[LINE_ADDR_W-1:ICACHE_IDX_W] : '0;

  icache_mshr u_mshr (
    .clk          (clk),
    .rst          (rst),
    .dmd_line_i   (dmd_line),
    .dmd_match_o  (dmd_match),
    .pf_line_i    (pf_line_q),
    .pf_match_o   (pf_match),
    .free_avail_o (free_avail),
    .alloc_en_i   (alloc_en),
    .alloc_line_i (alloc_line),
    .alloc_is_pf_i(alloc_is_pf),
    .iss_vld_o    (iss_vld),
    .iss_line_o   (iss_line),
    .iss_resp_i   (mem2proc_response_i),
    .ret_tag_i    (mem2proc_tag_i),
    .ret_hit_o    (ret_hit),
    .ret_line_o   (ret_line)
  );

  always_comb begin
    // Demand wins the single allocation slot; prefetch only takes it when
    // the probe misses both the cache and the MSHR table.
    dmd_alloc     = if_req_i & ~rd_hit_i & ~dmd_match & free_avail;
    pf_probe_miss = pf_active_q & ~pf_hit_i & ~pf_match;
    pf_alloc      = pf_probe_miss & ~dmd_alloc & free_avail;
    pf_adv        = pf_active_q & ~dmd_alloc & (~pf_probe_miss | pf_alloc);
    alloc_en      = dmd_alloc | pf_alloc;
    alloc_line    = dmd_alloc ? dmd_line : pf_line_q;
    alloc_is_pf   = ~dmd_alloc;

    pf_active_d = pf_active_q;
    pf_line_d   = pf_line_q;
    pf_limit_d  = pf_limit_q;
    if (dmd_alloc) begin
      pf_active_d = 1'b1;
      pf_line_d   = dmd_line + 1'b1;
      pf_limit_d  = dmd_line + LINE_ADDR_W'(PF_DEPTH);
    end else if (pf_adv) begin
      // Equality test on the limit keeps the window correct across wrap.
      if (pf_line_q == pf_limit_q) pf_active_d = 1'b0;
      pf_line_d = pf_line_q + 1'b1;
    end

    wr_en_d   = ret_hit;
    wr_line_d = ret_hit ? ret_line : wr_line_q;
    wr_data_d = ret_hit ? mem2proc_data_i : wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pf_active_q <= 1'b0;
      wr_en_q     <= 1'b0;
    end else begin
      pf_active_q <= pf_active_d;
      wr_en_q     <= wr_en_d;
    end
  end

  always_ff @(posedge clk) begin
    pf_line_q  <= pf_line_d;
    pf_limit_q <= pf_limit_d;
    wr_line_q  <= wr_line_d;
    wr_data_q  <= wr_data_d;
  end

  assign wr_en_o   = wr_en_q;
  assign wr_idx_o  = wr_line_q[ICACHE_IDX_W-1:0];
  assign wr_tag_o  = wr_line_q[LINE_ADDR_W-1:ICACHE_IDX_W];
  assign wr_data_o = wr_data_q;

  assign proc2mem_command_o = iss_vld ? BUS_LOAD : BUS_NONE;
  assign proc2mem_addr_o    = iss_vld ? line_to_addr(iss_line) : '0;

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
I-cache miss/fill controller that drives the write and prefetch-probe side of the 1-way I-cache array.
- Detects demand misses from the fetch stage and tracks them in a small MSHR table.
- Issues line loads on the tagged main-memory bus and writes returned lines into the cache.
- Runs a sequential next-line prefetcher that probes the cache and fetches only lines that miss.
- Sits between the fetch stage, the I-cache array, and the memory-bus arbiter port.

Parameters:
ADDR_W, 32, byte address width
IDX_W, 7, cache index width (1KB / 8B lines)
TAG_W, ADDR_W-IDX_W-3, cache tag width
LINE_W, 64, line / memory data width
NUM_MSHR, 4, outstanding line requests
PF_DEPTH, 2, lines prefetched ahead of the last demand miss
MEM_TAG_W, 4, memory transaction tag width (0 = none)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req_i  in  1  fetch request valid
if_pc_i  in  ADDR_W  fetch byte address
rd_idx_o  out  IDX_W  cache read index, equal to if_pc_i[IDX_W+2:3] (combinational)
rd_tag_o  out  TAG_W  cache read tag, equal to if_pc_i[ADDR_W-1:IDX_W+3]
rd_hit_i  in  1  cache read hit
pf_idx_o  out  IDX_W  prefetch probe index
pf_tag_o  out  TAG_W  prefetch probe tag
pf_hit_i  in  1  prefetch probe hit
wr_en_o  out  1  cache fill write enable
wr_idx_o  out  IDX_W  fill index
wr_tag_o  out  TAG_W  fill tag
wr_data_o  out  LINE_W  fill data
proc2mem_command_o  out  2  BUS_NONE / BUS_LOAD
proc2mem_addr_o  out  ADDR_W  line-aligned load address
mem2proc_response_i  in  MEM_TAG_W  nonzero = request accepted, value is the transaction tag
mem2proc_data_i  in  LINE_W  returned data
mem2proc_tag_i  in  MEM_TAG_W  nonzero = data for that tag is valid this cycle

Behaviour:
- Line address is {tag, idx}. Memory address is {line, 3'b0}.
- MSHR entry fields: vld, sent, is_pf, line, mem_tag. Allocation goes through a circular alloc pointer; entries are kept in age order.
- Demand miss: if_req_i & ~rd_hit_i, and the line is not already in a valid MSHR entry.
  - Allocate an entry at the clock edge.
  - Reload the prefetch pointer to line+1 and set the window limit to line+PF_DEPTH.
- Demand miss with all entries valid: no allocation. Fetch holds its request; allocation is retried every cycle.
- Demand miss to a line already in an MSHR: no allocation, no prefetch-window reload.
- Prefetch pointer handling:
  - pf_idx_o/pf_tag_o are driven from pf_line_r while the window is active (pf_line_r ≤ limit).
  - If pf_hit_i is set, or the line is already in an MSHR, advance the pointer.
  - Else, if a free entry exists and no demand allocation occurs this cycle, allocate with is_pf=1 and advance.
  - Else hold the pointer.
  - The window is inactive after reset and after passing the limit. Line arithmetic wraps modulo 2^(TAG_W+IDX_W).
- Issue:
  - proc2mem outputs are combinational: BUS_LOAD with the oldest vld&~sent entry, otherwise BUS_NONE with addr 0.
  - Nonzero response: set sent and store mem_tag at the edge.
  - Zero response: hold the same entry and address next cycle.
  - First issue occurs 1 cycle after the miss.
- Return: mem2proc_tag_i nonzero and matching a vld&sent entry.
  - Registered fill: wr_en_o=1 the next cycle with the entry's idx/tag and the captured data.
  - The entry is freed at the same edge as the capture.
  - Unmatched or zero tags are ignored.
- Same-cycle events: free, allocate, and issue-accept may all occur in one cycle. Allocation uses the pre-edge free vector, so a freed entry is reusable next cycle. Demand allocation has priority over prefetch.
- Only one allocation is made per cycle.
- Reset: all MSHR vld=0, prefetch window inactive, wr_en_o=0, proc2mem_command_o=BUS_NONE, proc2mem_addr_o=0. Responses for pre-reset transactions match nothing and are dropped.
- Redirect (demand miss to a new line): older prefetch entries stay live and fill normally.

Decomposition:
- Shared package:
  - bus command enum (BUS_NONE, BUS_LOAD, BUS_STORE)
  - mshr_entry_t struct
  - ICACHE_IDX_W, ICACHE_TAG_W, line-offset constants
- Sub-module icache_mshr holds the entry array and provides:
  - line-match CAM for demand and prefetch lookups
  - oldest-unsent select
  - mem_tag match
- icache_fill_ctrl keeps the prefetch pointer and the fill register.

Test Plan:
1. Demand miss, empty MSHR: pc=0x100, rd_hit=0, response=3.
   - Next cycle: LOAD addr=0x100.
   - Later tag=3, data=0xDEADBEEF → following cycle wr_en=1, idx=0x20, tag=0x0, data=0xDEADBEEF.
2. Response 0 for 3 cycles, then 5 → addr 0x100 held all 4 cycles; sent only after response 5.
3. PF_DEPTH=2 after miss 0x100, pf_hit=0 → LOADs 0x100, 0x108, 0x110 in order. Repeat with pf_hit=1 on 0x108 → only 0x100, 0x110.
4. Four outstanding misses, fifth demand miss → no allocation and no new command. Tag return frees an entry → fifth allocated the cycle after the free, issued one cycle later.
5. Demand miss to 0x108 already prefetched in flight → no duplicate LOAD; exactly one wr_en for idx 0x21.
6. rst asserted with 2 sent entries, then their tags return → wr_en stays 0 and command stays BUS_NONE.
